corr_pkt_arb: RTL and testbench
===============================

CORR_PKT_ARB -- requirements
Module: corr_pkt_arb

Interface
REQ-001 Parameter N_CH, default 4, number of correlator channels sharing one packet FIFO push port (2..16).
REQ-002 Parameter PKT_LEN, default 5, body bytes per channel packet (1..16).
REQ-003 Port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port i_cg  input  1  clock gate; when 0, all state holds.
REQ-006 Port i_strobe  input  N_CH  per-channel "packet ready" pulse (one cycle per packet).
REQ-007 Port i_pkt  input  N_CH*8*PKT_LEN  per-channel packet; channel c occupies slice [c*8*PKT_LEN +: 8*PKT_LEN]; byte 0 is the least significant byte.
REQ-008 Port i_flush  input  1  synchronous abort/clear.
REQ-009 Port i_fifoFull  input  1  downstream FIFO full.
REQ-010 Port o_push  output  1  downstream push strobe.
REQ-011 Port o_data  output  8  downstream push data.
REQ-012 Port o_busy  output  1  high when state is not IDLE.
REQ-013 Port o_pending  output  N_CH  per-channel holding register occupied.
REQ-014 Port o_dropCount  output  N_CH*8  per-channel saturating drop counters.

Function
REQ-015 Per-channel holding register: on i_strobe[c] capture i_pkt slice c and set pending[c] on the next edge.
REQ-016 If i_strobe[c] arrives while pending[c]=1 and channel c is not granted that cycle, discard the packet, keep the held data, and increment dropCount[c], saturating at 255.
REQ-017 If i_strobe[c] arrives in the cycle channel c is granted, the new packet is captured, pending[c] stays 1, and no drop is counted.
REQ-018 FSM states: IDLE, HDR, BODY.
REQ-019 IDLE: if any pending is set, grant one channel, copy its holding register into the send register, clear its pending, latch sel, and go to HDR next cycle.
REQ-020 Arbitration is round-robin: search starts at lastGrant+1 modulo N_CH; lastGrant updates on each grant.
REQ-021 HDR: o_data={4'hA, sel[3:0]} and o_push=!i_fifoFull; on a push, go to BODY with byteIdx=0; otherwise hold in HDR.
REQ-022 BODY: o_data=send byte byteIdx and o_push=!i_fifoFull; byteIdx increments only on a push; the push of byte PKT_LEN-1 returns the FSM to IDLE.
REQ-023 o_push is never asserted in IDLE. Every grant has exactly one bubble cycle in IDLE, so packet-to-packet spacing is at least PKT_LEN+2 cycles.
REQ-024 Latency: strobe in cycle 0 with FSM idle, not full, no flush -> header pushed in cycle 2, last body byte pushed in cycle 2+PKT_LEN.
REQ-025 i_flush has priority over all other activity: it clears all pending, all dropCount, and byteIdx, forces IDLE on the next edge, and forces o_push=0 in the flush cycle; a strobe in the flush cycle is discarded and not counted.
REQ-026 o_data is 8'h00 whenever o_push=0.
REQ-027 When i_cg=0, o_push is 0 and strobes are ignored.

Reset
REQ-028 While i_rst_n=0 (asynchronous): state=IDLE, pending=0, dropCount=0, byteIdx=0, lastGrant=N_CH-1, o_push=0, o_data=0, o_busy=0.
REQ-029 Holding and send registers are not reset.
REQ-030 Reset asserted mid-packet aborts the packet with no further pushes; after release, the first grant goes to the lowest-numbered pending channel.

Verification
REQ-031 Defaults; strobe ch2 with packet bytes 11,22,33,44,55, FIFO never full -> pushes A2,11,22,33,44,55 in cycles 2..7; o_busy high in cycles 2..7.
REQ-032 Strobe ch0..ch3 in the same cycle -> headers are emitted in order A0,A1,A2,A3, each followed by 5 bytes, with one idle cycle between packets.
REQ-033 i_fifoFull high for 3 cycles during BODY byte 1 -> that byte is held, no push and no duplicate, then the sequence resumes intact.
REQ-034 Three strobes on ch1 while ch1 is blocked behind ch0 -> dropCount[1]=2, and the first held ch1 packet is sent.
REQ-035 i_flush during BODY byte 3 -> no push in the flush cycle, IDLE next cycle, pending=0, dropCount=0; a subsequent strobe is served normally.
REQ-036 300 overflowing strobes on ch3 -> dropCount[3] saturates at 255 and does not wrap.

Source files
------------

// File: rtl/corr_pkt_arb.sv
// Round-robin arbiter that serialises per-channel correlator packets onto one
// byte-wide FIFO push port as a header byte {4'hA, channel} plus PKT_LEN body bytes.
module corr_pkt_arb #(
    parameter int N_CH    = 4,
    parameter int PKT_LEN = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cg,
    input  logic [N_CH-1:0]           i_strobe,
    input  logic [N_CH*8*PKT_LEN-1:0] i_pkt,
    input  logic                      i_flush,
    input  logic                      i_fifoFull,
    output logic                      o_push,
    output logic [7:0]                o_data,
    output logic                      o_busy,
    output logic [N_CH-1:0]           o_pending,
    output logic [N_CH*8-1:0]         o_dropCount
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int PW = 8 * PKT_LEN;
    localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   last_q, last_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [7:0]      drop_q [N_CH];
    logic [7:0]      drop_d [N_CH];
    logic [PW-1:0]   hold_q [N_CH];
    logic [PW-1:0]   send_q;

    logic            active;
    logic            gnt_found;
    logic [CW-1:0]   gnt_idx;
    logic            grant;
    logic [N_CH-1:0] is_gnt;
    logic [N_CH-1:0] cap;
    logic            push;
    logic [7:0]      data;

    assign active = i_cg && !i_flush;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!gnt_found && pend_q[(int'(last_q) + k) % N_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'((int'(last_q) + k) % N_CH);
            end
        end
    end

    assign grant = active && (state_q == S_IDLE) && gnt_found;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic drop_inc;

            assign is_gnt[gi] = grant && (gnt_idx == CW'(gi));
            // A strobe is accepted into an empty slot, or into the slot being emptied by this grant.
            assign cap[gi]    = active && i_strobe[gi] && (!pend_q[gi] || is_gnt[gi]);
            assign drop_inc   = active && i_strobe[gi] && pend_q[gi] && !is_gnt[gi];

            assign pend_d[gi] = !i_cg       ? pend_q[gi] :
                                i_flush     ? 1'b0       :
                                cap[gi]     ? 1'b1       :
                                is_gnt[gi]  ? 1'b0       : pend_q[gi];

            assign drop_d[gi] = !i_cg                                ? drop_q[gi] :
                                i_flush                              ? 8'h00      :
                                (drop_inc && drop_q[gi] != 8'hFF)    ? drop_q[gi] + 8'h01 :
                                                                       drop_q[gi];

            assign o_dropCount[gi*8 +: 8] = drop_q[gi];

            always_ff @(posedge i_clk) begin
                if (cap[gi]) begin
                    hold_q[gi] <= i_pkt[gi*PW +: PW];
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        byte_d  = byte_q;
        push    = 1'b0;
        data    = 8'h00;
        if (i_cg) begin
            if (i_flush) begin
                state_d = S_IDLE;
                byte_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (gnt_found) begin
                            state_d = S_HDR;
                            sel_d   = gnt_idx;
                            last_d  = gnt_idx;
                        end
                    end
                    S_HDR: begin
                        if (!i_fifoFull) begin
                            push    = 1'b1;
                            data    = {4'hA, 4'(sel_q)};
                            state_d = S_BODY;
                            byte_d  = '0;
                        end
                    end
                    S_BODY: begin
                        if (!i_fifoFull) begin
                            push = 1'b1;
                            data = send_q[int'(byte_q)*8 +: 8];
                            if (byte_q == LAST_BYTE) begin
                                state_d = S_IDLE;
                                byte_d  = '0;
                            end else begin
                                byte_d = byte_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= CW'(N_CH - 1);
            byte_q  <= '0;
            pend_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                drop_q[c] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            pend_q  <= pend_d;
            for (int c = 0; c < N_CH; c++) begin
                drop_q[c] <= drop_d[c];
            end
        end
    end

    // Snapshot taken at grant so the channel can refill its holding slot while sending.
    always_ff @(posedge i_clk) begin
        if (grant) begin
            send_q <= hold_q[gnt_idx];
        end
    end

    assign o_push    = push;
    assign o_data    = data;
    assign o_busy    = (state_q != S_IDLE);
    assign o_pending = pend_q;

endmodule

// File: tb/tb_corr_pkt_arb.sv
// Bench for corr_pkt_arb: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a byte-queue model of the arbiter.
module tb_corr_pkt_arb;

    localparam int N  = 4;
    localparam int L  = 5;
    localparam int PW = 8 * L;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_cg;
    logic [N-1:0]      i_strobe;
    logic [N*PW-1:0]   i_pkt;
    logic              i_flush;
    logic              i_fifoFull;
    logic              o_push;
    logic [7:0]        o_data;
    logic              o_busy;
    logic [N-1:0]      o_pending;
    logic [N*8-1:0]    o_dropCount;

    always #5 clk = ~clk;

    corr_pkt_arb #(.N_CH(N), .PKT_LEN(L)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_cg        (i_cg),
        .i_strobe    (i_strobe),
        .i_pkt       (i_pkt),
        .i_flush     (i_flush),
        .i_fifoFull  (i_fifoFull),
        .o_push      (o_push),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_pending   (o_pending),
        .o_dropCount (o_dropCount)
    );

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;

    // Model: holding slots, pending flags, drop counts, and the bytes still to send.
    logic [7:0] m_hold [N][L];
    bit         m_pend [N];
    int         m_drop [N];
    int         m_last;
    logic [7:0] m_q [$];

    logic [7:0] pushlog [$];
    int         pushcyc [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pend[c] = 1'b0;
            m_drop[c] = 0;
        end
        m_last = N - 1;
        m_q.delete();
    endtask

    function automatic logic [N*PW-1:0] rnd_pkt();
        logic [N*PW-1:0] r;
        r = '0;
        for (int i = 0; i < N * PW; i += 8) begin
            r[i +: 8] = 8'($urandom_range(0, 255));
        end
        return r;
    endfunction

    task automatic cycle(input logic cg, input logic flush, input logic full,
                         input logic [N-1:0] stb, input logic [N*PW-1:0] pkt);
        logic       e_push;
        logic [7:0] e_data;
        logic [N-1:0]   e_pend;
        logic [N*8-1:0] e_drop;
        bit         oldp [N];
        int         g;
        @(negedge clk);
        i_cg       = cg;
        i_flush    = flush;
        i_fifoFull = full;
        i_strobe   = stb;
        i_pkt      = pkt;
        #1;
        e_push = cg && !flush && (m_q.size() > 0) && !full;
        e_data = e_push ? m_q[0] : 8'h00;
        for (int c = 0; c < N; c++) begin
            e_pend[c]       = m_pend[c];
            e_drop[c*8 +: 8] = 8'(m_drop[c]);
        end
        check_val("push", 64'(o_push), 64'(e_push));
        check_val("data", 64'(o_data), 64'(e_data));
        check_val("busy", 64'(o_busy), 64'(m_q.size() > 0));
        check_val("pending", 64'(o_pending), 64'(e_pend));
        check_val("dropcnt", 64'(o_dropCount), 64'(e_drop));
        if (o_push) begin
            pushlog.push_back(o_data);
            pushcyc.push_back(cyc);
        end
        if (cg) begin
            if (flush) begin
                for (int c = 0; c < N; c++) begin
                    m_pend[c] = 1'b0;
                    m_drop[c] = 0;
                end
                m_q.delete();
            end else begin
                g = -1;
                for (int c = 0; c < N; c++) oldp[c] = m_pend[c];
                if (m_q.size() > 0) begin
                    if (!full) void'(m_q.pop_front());
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
                    end
                    if (g >= 0) begin
                        m_q.push_back(8'hA0 + 8'(g));
                        for (int b = 0; b < L; b++) m_q.push_back(m_hold[g][b]);
                        m_pend[g] = 1'b0;
                        m_last    = g;
                    end
                end
                for (int c = 0; c < N; c++) begin
                    if (stb[c]) begin
                        if (!oldp[c] || c == g) begin
                            for (int b = 0; b < L; b++) m_hold[c][b] = pkt[c*PW + b*8 +: 8];
                            m_pend[c] = 1'b1;
                        end else if (m_drop[c] < 255) begin
                            m_drop[c]++;
                        end
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n    = 1'b0;
        i_cg       = 1'b1;
        i_flush    = 1'b0;
        i_fifoFull = 1'b0;
        i_strobe   = '0;
        i_pkt      = '0;
        #1;
        check_val("rst_push", 64'(o_push), 64'd0);
        check_val("rst_data", 64'(o_data), 64'd0);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_pend", 64'(o_pending), 64'd0);
        check_val("rst_drop", 64'(o_dropCount), 64'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        model_reset();
        pushlog.delete();
        pushcyc.delete();
    endtask

    initial begin
        logic [N*PW-1:0] p;
        logic [N*PW-1:0] p1;
        logic [7:0]      exp31 [6];
        int              base;

        i_rst_n = 1'b0; i_cg = 1'b0; i_flush = 1'b0; i_fifoFull = 1'b0;
        i_strobe = '0; i_pkt = '0;
        model_reset();
        for (int c = 0; c < N; c++)
            for (int b = 0; b < L; b++) m_hold[c][b] = 8'h00;
        repeat (2) @(posedge clk);

        // Single packet on ch2: latency and byte order.
        do_reset();
        p = '0;
        p[2*PW +: PW] = 40'h5544332211;
        base = cyc;
        cycle(1'b1, 1'b0, 1'b0, 4'b0100, p);
        idle(9);
        exp31 = '{8'hA2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_val("r31_len", 64'(pushlog.size()), 64'd6);
        if (pushlog.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check_val("r31_byte", 64'(pushlog[i]), 64'(exp31[i]));
                check_val("r31_cyc", 64'(pushcyc[i] - base), 64'(2 + i));
            end
        end
        $display("txn r31 single ch2 pushes=%0d", pushlog.size());

        // All four channels at once: round-robin order with one bubble between packets.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'b1111, rnd_pkt());
        idle(32);
        check_val("r32_len", 64'(pushlog.size()), 64'd24);
        if (pushlog.size() == 24) begin
            for (int i = 0; i < 4; i++) check_val("r32_hdr", 64'(pushlog[i*6]), 64'(8'hA0 + 8'(i)));
            for (int i = 0; i < 3; i++) check_val("r32_gap", 64'(pushcyc[(i+1)*6] - pushcyc[i*6+5]), 64'd2);
        end
        $display("txn r32 four channels pushes=%0d", pushlog.size());

        // FIFO full for 3 cycles while body byte 1 is due.
        do_reset();
        p = rnd_pkt();
        cycle(1'b1, 1'b0, 1'b0, 4'b0001, p);
        idle(3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, '0, '0);
        idle(8);
        check_val("r33_len", 64'(pushlog.size()), 64'd6);
        if (pushlog.size() == 6) begin
            for (int b = 0; b < L; b++) check_val("r33_byte", 64'(pushlog[1+b]), 64'(p[b*8 +: 8]));
        end
        $display("txn r33 stall pushes=%0d", pushlog.size());

        // ch1 blocked behind ch0, then strobed twice more.
        do_reset();
        p1 = rnd_pkt();
        cycle(1'b1, 1'b0, 1'b0, 4'b0011, p1);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 4'b0010, rnd_pkt());
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, 4'b0010, rnd_pkt());
        idle(16);
        check_val("r34_drop1", 64'(o_dropCount[15:8]), 64'd2);
        check_val("r34_len", 64'(pushlog.size()), 64'd12);
        if (pushlog.size() == 12) begin
            check_val("r34_hdr", 64'(pushlog[6]), 64'hA1);
            for (int b = 0; b < L; b++) check_val("r34_byte", 64'(pushlog[7+b]), 64'(p1[PW + b*8 +: 8]));
        end
        $display("txn r34 drops ch1=%0d", o_dropCount[15:8]);

        // Flush during body byte 3, with a drop recorded beforehand.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'b0100, rnd_pkt());
        cycle(1'b1, 1'b0, 1'b0, 4'b0010, rnd_pkt());
        cycle(1'b1, 1'b0, 1'b0, 4'b0010, rnd_pkt());
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 4'b1000, rnd_pkt());
        check_val("r35_flushpush", 64'(o_push), 64'd0);
        pushlog.delete();
        pushcyc.delete();
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check_val("r35_busy", 64'(o_busy), 64'd0);
        check_val("r35_pend", 64'(o_pending), 64'd0);
        check_val("r35_drop", 64'(o_dropCount), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'b1000, rnd_pkt());
        idle(9);
        check_val("r35_len", 64'(pushlog.size()), 64'd6);
        if (pushlog.size() == 6) check_val("r35_hdr", 64'(pushlog[0]), 64'hA3);
        $display("txn r35 flush then ch3 pushes=%0d", pushlog.size());

        // 300 overflowing strobes on ch3 with the FIFO stuck full.
        do_reset();
        for (int i = 0; i < 302; i++) cycle(1'b1, 1'b0, 1'b1, 4'b1000, rnd_pkt());
        check_val("r36_sat", 64'(o_dropCount[31:24]), 64'd255);
        $display("txn r36 saturate ch3=%0d", o_dropCount[31:24]);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'b1110, rnd_pkt());
        idle(4);
        do_reset();
        idle(3);
        check_val("r30_quiet", 64'(pushlog.size()), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'b1010, rnd_pkt());
        idle(3);
        check_val("r30_len", 64'(pushlog.size()), 64'd2);
        if (pushlog.size() >= 1) check_val("r30_first", 64'(pushlog[0]), 64'hA1);
        $display("txn r30 midpacket reset first=%0h", pushlog.size() > 0 ? pushlog[0] : 8'h00);

        // Randomized traffic including clock gating, flushes and back-pressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] s;
            for (int c = 0; c < N; c++) s[c] = ($urandom_range(0, 99) < 15);
            cycle($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 30, s, rnd_pkt());
        end
        $display("txn random cycles=3000 pushes=%0d", pushlog.size());

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
